// File: rtl/counter_pred_ctrl_pkg.sv
// Shared types and defaults for the branch-predictor
// counter-table controller.
package counter_pred_ctrl_pkg;

  localparam int IDXW             = 7;
  localparam int CNTW             = 2;
  localparam int DEF_FIFO_DEPTH   = 8;
  localparam int DEF_ATTEN_PERIOD = 256;

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic            taken;
  } fifo_entry_t;

endpackage

// File: rtl/counter_pred_ctrl_fifo.sv
// In-order queue of predictions awaiting resolution.
// Pointers carry one extra wrap bit.
module pred_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !clr) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

  assign count = wptr_q - rptr_q;
  assign empty = (count == '0);
  assign rdata = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/counter_pred_ctrl.sv
// Lookup/update initiator for the 128-entry 2-bit
// saturating counter table.
module counter_pred_ctrl
  import counter_pred_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int ATTEN_PERIOD = DEF_ATTEN_PERIOD
) (
  input  logic            Clk,
  input  logic            Rest,
  input  logic            PredValid,
  input  logic [IDXW-1:0] PredIdx,
  output logic            PredReady,
  output logic            PredRespValid,
  output logic            PredTaken,
  output logic            PredStrong,
  input  logic            ResValid,
  input  logic            ResTaken,
  output logic            ResReady,
  input  logic            Flush,
  output logic [IDXW-1:0] Raddr,
  output logic            Rable,
  output logic            Atten,
  output logic [IDXW-1:0] Waddr,
  output logic            Wable,
  output logic            Wdate,
  input  logic [CNTW-1:0] Rdate
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int IW  = CW + 1;
  localparam int ATW = $clog2(ATTEN_PERIOD);
  localparam logic [IW-1:0] DEPTH_W = IW'(FIFO_DEPTH);

  logic            s0_v_q, s0_v_d;
  logic [IDXW-1:0] s0_idx_q, s0_idx_d;
  logic            s1_v_q, s1_v_d;
  logic [IDXW-1:0] s1_idx_q, s1_idx_d;
  logic            atten_q, atten_d;
  logic [ATW-1:0]  acnt_q, acnt_d;
  logic            wable_q, wable_d;
  logic [IDXW-1:0] waddr_q, waddr_d;
  logic            wdate_q, wdate_d;

  logic            accept, pop, push;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_cnt;
  logic [IW-1:0]   inflight;
  fifo_entry_t     head, push_e;

  // Every lookup past S0 holds a reserved FIFO slot.
  assign inflight = {1'b0, fifo_cnt}
                  + {{CW{1'b0}}, s0_v_q}
                  + {{CW{1'b0}}, s1_v_q};

  assign PredReady = !Rest && !Flush && (inflight < DEPTH_W);
  assign ResReady  = !Rest && !Flush && !fifo_empty;
  assign accept    = PredValid && PredReady;
  assign pop       = ResValid && ResReady;
  assign push      = s1_v_q;

  assign PredRespValid = s1_v_q;
  assign PredTaken     = s1_v_q & Rdate[1];
  assign PredStrong    = s1_v_q & (Rdate[1] == Rdate[0]);

  assign push_e.idx   = s1_idx_q;
  assign push_e.taken = PredTaken;

  always_comb begin
    s0_v_d   = accept;
    s0_idx_d = accept ? PredIdx : s0_idx_q;
    s1_v_d   = s0_v_q && !Flush;
    s1_idx_d = s0_idx_q;
    // Pulse rides on the read cycle of the wrapping lookup.
    atten_d  = accept && (&acnt_q);
    acnt_d   = accept ? acnt_q + 1'b1 : acnt_q;
    wable_d  = pop;
    waddr_d  = pop ? head.idx : waddr_q;
    wdate_d  = pop ? (head.taken == ResTaken) : wdate_q;
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      s0_v_q   <= 1'b0;
      s0_idx_q <= '0;
      s1_v_q   <= 1'b0;
      s1_idx_q <= '0;
      atten_q  <= 1'b0;
      acnt_q   <= '0;
      wable_q  <= 1'b0;
      waddr_q  <= '0;
      wdate_q  <= 1'b0;
    end else begin
      s0_v_q   <= s0_v_d;
      s0_idx_q <= s0_idx_d;
      s1_v_q   <= s1_v_d;
      s1_idx_q <= s1_idx_d;
      atten_q  <= atten_d;
      acnt_q   <= acnt_d;
      wable_q  <= wable_d;
      waddr_q  <= waddr_d;
      wdate_q  <= wdate_d;
    end
  end

  pred_fifo #(
    .DW    ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rest),
    .clr   (Flush | Rest),
    .push  (push),
    .wdata (push_e),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign Raddr = s0_idx_q;
  assign Rable = s0_v_q;
  assign Atten = atten_q;
  assign Waddr = waddr_q;
  assign Wable = wable_q;
  assign Wdate = wdate_q;

endmodule

// File: tb/tb_counter_pred_ctrl.sv
// Scoreboard bench for counter_pred_ctrl with a short
// attenuation period.
module tb_counter_pred_ctrl;

  logic       Clk = 1'b0;
  logic       Rest = 1'b1;
  logic       PredValid = 1'b0;
  logic [6:0] PredIdx = '0;
  logic       ResValid = 1'b0;
  logic       ResTaken = 1'b0;
  logic       Flush = 1'b0;
  logic [1:0] Rdate;
  logic       PredReady, PredRespValid, PredTaken, PredStrong;
  logic       ResReady, Rable, Atten, Wable, Wdate;
  logic [6:0] Raddr, Waddr;

  counter_pred_ctrl #(
    .FIFO_DEPTH   (8),
    .ATTEN_PERIOD (4)
  ) dut (
    .Clk           (Clk),
    .Rest          (Rest),
    .PredValid     (PredValid),
    .PredIdx       (PredIdx),
    .PredReady     (PredReady),
    .PredRespValid (PredRespValid),
    .PredTaken     (PredTaken),
    .PredStrong    (PredStrong),
    .ResValid      (ResValid),
    .ResTaken      (ResTaken),
    .ResReady      (ResReady),
    .Flush         (Flush),
    .Raddr         (Raddr),
    .Rable         (Rable),
    .Atten         (Atten),
    .Waddr         (Waddr),
    .Wable         (Wable),
    .Wdate         (Wdate),
    .Rdate         (Rdate)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Table model: data appears the cycle after the read.
  logic [1:0] tbl [128];
  logic [6:0] rq = '0;
  always @(posedge Clk) rq <= Raddr;
  assign Rdate = tbl[rq];

  typedef struct { int due; logic [6:0] idx; logic at; } rd_t;
  typedef struct { int due; logic tk; logic st; } rs_t;
  typedef struct { int due; logic [6:0] idx; logic wd; } wr_t;
  typedef struct { int due; logic [6:0] idx; logic tk; } if_t;

  rd_t rd_q[$];
  rs_t rs_q[$];
  wr_t wr_q[$];
  if_t inf[$];

  int vecs = 0;
  int errs = 0;
  bit mon_en = 0;
  int acc_n = 0;

  task automatic nxt();
    @(negedge Clk);
    #1;
  endtask

  task automatic drive(input bit pv, input logic [6:0] pi,
                       input bit rv, input bit rt, input bit fl);
    int k;
    bit pr, rr;
    logic [1:0] t;
    if_t e;
    k  = cyc;
    pr = !fl && (inf.size() < 8);
    rr = !fl && (inf.size() > 0) && (inf[0].due < k);
    if (fl) begin
      while (rs_q.size() > 0 && rs_q[$].due >= k + 1)
        void'(rs_q.pop_back());
      inf.delete();
    end
    if (rv && rr) begin
      e = inf.pop_front();
      wr_q.push_back('{k + 1, e.idx, e.tk == rt});
    end
    if (pv && pr) begin
      t = tbl[pi];
      rd_q.push_back('{k + 1, pi, acc_n == 3});
      acc_n = (acc_n + 1) % 4;
      rs_q.push_back('{k + 2, t[1], t[1] == t[0]});
      inf.push_back('{k + 2, pi, t[1]});
    end
    PredValid = pv;
    PredIdx   = pi;
    ResValid  = rv;
    ResTaken  = rt;
    Flush     = fl;
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      vecs++;
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        if (Rable !== 1'b1 || Raddr !== rd_q[0].idx
            || Atten !== rd_q[0].at) begin
          errs++;
          $display("FAIL rd_port cyc=%0d got Rable=%b Raddr=%h Atten=%b want 1 %h %b",
                   cyc, Rable, Raddr, Atten, rd_q[0].idx, rd_q[0].at);
        end
        void'(rd_q.pop_front());
      end else if (Rable !== 1'b0 || Atten !== 1'b0) begin
        errs++;
        $display("FAIL rd_idle cyc=%0d got Rable=%b Atten=%b want 0 0",
                 cyc, Rable, Atten);
      end
      vecs++;
      if (rs_q.size() > 0 && rs_q[0].due == cyc) begin
        if (PredRespValid !== 1'b1 || PredTaken !== rs_q[0].tk
            || PredStrong !== rs_q[0].st) begin
          errs++;
          $display("FAIL resp cyc=%0d got v=%b tk=%b st=%b want 1 %b %b",
                   cyc, PredRespValid, PredTaken, PredStrong,
                   rs_q[0].tk, rs_q[0].st);
        end
        void'(rs_q.pop_front());
      end else if (PredRespValid !== 1'b0) begin
        errs++;
        $display("FAIL resp_idle cyc=%0d got v=%b want 0", cyc, PredRespValid);
      end
      vecs++;
      if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
        if (Wable !== 1'b1 || Waddr !== wr_q[0].idx
            || Wdate !== wr_q[0].wd) begin
          errs++;
          $display("FAIL wr_port cyc=%0d got Wable=%b Waddr=%h Wdate=%b want 1 %h %b",
                   cyc, Wable, Waddr, Wdate, wr_q[0].idx, wr_q[0].wd);
        end
        void'(wr_q.pop_front());
      end else if (Wable !== 1'b0) begin
        errs++;
        $display("FAIL wr_idle cyc=%0d got Wable=%b want 0", cyc, Wable);
      end
    end
  end

  task automatic test_reset();
    mon_en = 0;
    Rest = 1'b1;
    PredValid = 0; ResValid = 0; Flush = 0;
    rd_q.delete(); rs_q.delete(); wr_q.delete(); inf.delete();
    acc_n = 0;
    nxt();
    vecs++;
    if (PredReady !== 1'b0 || ResReady !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready got pr=%b rr=%b want 0 0", PredReady, ResReady);
    end
    nxt();
    Rest = 1'b0;
    mon_en = 1;
    nxt();
    vecs++;
    if (PredReady !== 1'b1 || ResReady !== 1'b0 || PredRespValid !== 1'b0
        || Raddr !== 7'h0 || Rable !== 1'b0 || Atten !== 1'b0
        || Waddr !== 7'h0 || Wable !== 1'b0 || Wdate !== 1'b0) begin
      errs++;
      $display("FAIL reset_vals got pr=%b rr=%b v=%b ra=%h re=%b at=%b wa=%h we=%b wd=%b want 1 0 0 00 0 0 00 0 0",
               PredReady, ResReady, PredRespValid, Raddr, Rable, Atten,
               Waddr, Wable, Wdate);
    end
  endtask

  task automatic test_single();
    for (int r = 0; r < 2; r++) begin
      nxt();
      vecs++;
      if (PredReady !== 1'b1) begin
        errs++;
        $display("FAIL single_ready got %b want 1", PredReady);
      end
      drive(1, 7'h05, 0, 0, 0);
      nxt();
      vecs++;
      if (Rable !== 1'b1 || Raddr !== 7'h05) begin
        errs++;
        $display("FAIL single_read got %b %h want 1 05", Rable, Raddr);
      end
      drive(0, 0, 0, 0, 0);
      nxt();
      vecs++;
      if (PredRespValid !== 1'b1 || PredTaken !== 1'b1 || PredStrong !== 1'b1) begin
        errs++;
        $display("FAIL single_resp got %b%b%b want 111",
                 PredRespValid, PredTaken, PredStrong);
      end
      nxt();
      vecs++;
      if (ResReady !== 1'b1) begin
        errs++;
        $display("FAIL single_resready got %b want 1", ResReady);
      end
      drive(0, 0, 1, r[0], 0);
      nxt();
      vecs++;
      if (Wable !== 1'b1 || Waddr !== 7'h05 || Wdate !== r[0]) begin
        errs++;
        $display("FAIL single_upd got %b %h %b want 1 05 %b",
                 Wable, Waddr, Wdate, r[0]);
      end
      drive(0, 0, 0, 0, 0);
      nxt();
      vecs++;
      if (ResReady !== 1'b0 || Wable !== 1'b0) begin
        errs++;
        $display("FAIL single_after got rr=%b we=%b want 0 0", ResReady, Wable);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      nxt();
      drive(0, 0, 1, 1'($urandom_range(0, 1)), 0);
    end
    nxt();
    drive(0, 0, 0, 0, 0);
    nxt();
    vecs++;
    if (ResReady !== 1'b0 || PredReady !== 1'b1) begin
      errs++;
      $display("FAIL drain_end got rr=%b pr=%b want 0 1", ResReady, PredReady);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    for (int i = 0; i < 10; i++) begin
      nxt();
      vecs++;
      if (PredReady !== (i < 8)) begin
        errs++;
        $display("FAIL b2b_ready i=%0d got %b want %b", i, PredReady, i < 8);
      end
      if (PredReady === 1'b1) n++;
      drive(1, 7'(16 + i), 0, 0, 0);
    end
    vecs++;
    if (n != 8) begin
      errs++;
      $display("FAIL b2b_count got %0d want 8", n);
    end
    for (int i = 0; i < 3; i++) begin
      nxt();
      drive(0, 0, 0, 0, 0);
    end
    nxt();
    vecs++;
    if (PredReady !== 1'b0 || ResReady !== 1'b1) begin
      errs++;
      $display("FAIL full_state got pr=%b rr=%b want 0 1", PredReady, ResReady);
    end
    drive(1, 7'h40, 1, 1, 0);
    nxt();
    vecs++;
    if (PredReady !== 1'b1) begin
      errs++;
      $display("FAIL refill_ready got %b want 1", PredReady);
    end
    drive(1, 7'h40, 0, 0, 0);
    nxt();
    vecs++;
    if (PredReady !== 1'b0) begin
      errs++;
      $display("FAIL refull_ready got %b want 0", PredReady);
    end
    drive(0, 0, 0, 0, 0);
    drain();
  endtask

  task automatic test_atten();
    test_reset();
    for (int i = 0; i < 9; i++) begin
      nxt();
      drive(1, 7'(40 + i), 0, 0, 0);
      nxt();
      vecs++;
      if (Rable !== 1'b1 || Atten !== (i == 3 || i == 7)) begin
        errs++;
        $display("FAIL atten i=%0d got re=%b at=%b want 1 %b",
                 i, Rable, Atten, i == 3 || i == 7);
      end
      drive(0, 0, 0, 0, 0);
      nxt();
      nxt();
      drive(0, 0, 1, 0, 0);
      nxt();
      drive(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_flush();
    nxt(); drive(1, 7'h50, 0, 0, 0);
    nxt(); drive(1, 7'h51, 0, 0, 0);
    nxt(); drive(1, 7'h52, 0, 0, 0);
    nxt(); drive(0, 0, 0, 0, 0);
    nxt();
    nxt(); drive(1, 7'h53, 0, 0, 0);
    nxt(); drive(0, 0, 0, 0, 0);
    nxt();
    vecs++;
    if (ResReady !== 1'b1 || PredRespValid !== 1'b1) begin
      errs++;
      $display("FAIL pre_flush got rr=%b v=%b want 1 1", ResReady, PredRespValid);
    end
    drive(0, 0, 1, 1, 1);
    #1;
    vecs++;
    if (ResReady !== 1'b0 || PredReady !== 1'b0) begin
      errs++;
      $display("FAIL flush_ready got rr=%b pr=%b want 0 0", ResReady, PredReady);
    end
    nxt();
    vecs++;
    if (PredRespValid !== 1'b0 || Wable !== 1'b0) begin
      errs++;
      $display("FAIL post_flush got v=%b we=%b want 0 0", PredRespValid, Wable);
    end
    drive(0, 0, 0, 0, 0);
    nxt();
    vecs++;
    if (ResReady !== 1'b0 || PredReady !== 1'b1) begin
      errs++;
      $display("FAIL flush_drop got rr=%b pr=%b want 0 1", ResReady, PredReady);
    end
    drive(1, 7'h54, 0, 0, 0);
    nxt();
    vecs++;
    if (Rable !== 1'b1 || Raddr !== 7'h54) begin
      errs++;
      $display("FAIL flush_new got %b %h want 1 54", Rable, Raddr);
    end
    drive(0, 0, 0, 0, 0);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) tbl[i] = 2'(i ^ (i >> 2));
    tbl[5] = 2'b11;
    test_reset();
    test_single();
    test_back_to_back();
    test_atten();
    test_flush();
    for (int i = 0; i < 4; i++) nxt();
    vecs++;
    if (rd_q.size() + rs_q.size() + wr_q.size() != 0) begin
      errs++;
      $display("FAIL leftover got %0d pending want 0",
               rd_q.size() + rs_q.size() + wr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
